// File: rtl/sorter_pkg.sv
// Shared constants, state encoding and weight classifier
// for the scale-station sorter scheduler.
package sorter_pkg;

    localparam int GRP_W = 3;

    localparam logic [31:0] TH_G1 = 32'd251;
    localparam logic [31:0] TH_G2 = 32'd501;
    localparam logic [31:0] TH_G3 = 32'd751;
    localparam logic [31:0] TH_G4 = 32'd1501;
    localparam logic [31:0] TH_G5 = 32'd2001;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SAMPLE  = 2'd1,
        UPDATE  = 2'd2,
        RELEASE = 2'd3
    } state_t;

    // Zero weight is its own group; the rest are bucketed by upper bounds.
    function automatic logic [GRP_W-1:0] classify(input logic [31:0] w);
        if (w == 32'd0)
            return 3'd0;
        else if (w < TH_G1)
            return 3'd1;
        else if (w < TH_G2)
            return 3'd2;
        else if (w < TH_G3)
            return 3'd3;
        else if (w < TH_G4)
            return 3'd4;
        else if (w < TH_G5)
            return 3'd5;
        else
            return 3'd6;
    endfunction

endpackage

// File: rtl/sorter_rr_arbiter.sv
// Round-robin next-grant picker: the first requester
// strictly after rr_ptr, wrapping cyclically.
module sorter_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid
);

    // Scan far-to-near so the nearest requester after rr_ptr wins.
    always_comb begin
        int cand;
        cand        = 0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int off = N_REQ; off >= 1; off--) begin
            cand = (int'(rr_ptr) + off) % N_REQ;
            if (req[cand]) begin
                grant_idx   = IDX_W'(cand);
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sorter_scheduler.sv
// Shares one classifier and the group counters between
// N_REQ scale stations using round-robin arbitration.
module sorter_scheduler
    import sorter_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int W_WIDTH   = 12,
    parameter int CNT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*W_WIDTH-1:0] weight,
    input  logic                     clr,
    output logic [N_REQ-1:0]         ack,
    output logic [GRP_W-1:0]         ack_grp,
    output logic                     busy,
    output logic [CNT_WIDTH-1:0]     Grp1,
    output logic [CNT_WIDTH-1:0]     Grp2,
    output logic [CNT_WIDTH-1:0]     Grp3,
    output logic [CNT_WIDTH-1:0]     Grp4,
    output logic [CNT_WIDTH-1:0]     Grp5,
    output logic [CNT_WIDTH-1:0]     Grp6
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t               state;
    logic [IDX_W-1:0]     rr_ptr;
    logic [IDX_W-1:0]     idx_q;
    logic [IDX_W-1:0]     grant_idx;
    logic                 grant_valid;
    logic [W_WIDTH-1:0]   w_q;
    logic [GRP_W-1:0]     grp_q;
    logic [CNT_WIDTH-1:0] cnt [1:6];

    sorter_rr_arbiter #(
        .N_REQ(N_REQ),
        .IDX_W(IDX_W)
    ) u_arb (
        .req        (req),
        .rr_ptr     (rr_ptr),
        .grant_idx  (grant_idx),
        .grant_valid(grant_valid)
    );

    // Transaction FSM; ack and ack_grp are registered on leaving UPDATE.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            rr_ptr  <= IDX_W'(N_REQ - 1);
            idx_q   <= '0;
            w_q     <= '0;
            grp_q   <= '0;
            ack     <= '0;
            ack_grp <= '0;
        end else begin
            ack <= '0;
            unique case (state)
                IDLE: begin
                    if (grant_valid) begin
                        idx_q  <= grant_idx;
                        rr_ptr <= grant_idx;
                        w_q    <= weight[grant_idx*W_WIDTH +: W_WIDTH];
                        state  <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    grp_q <= classify(32'(w_q));
                    state <= UPDATE;
                end
                UPDATE: begin
                    ack[idx_q] <= 1'b1;
                    ack_grp    <= grp_q;
                    state      <= RELEASE;
                end
                RELEASE: begin
                    if (!req[idx_q])
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Group counters; clr beats the UPDATE increment.
    always_ff @(posedge clk) begin
        if (!reset || clr) begin
            for (int g = 1; g <= 6; g++)
                cnt[g] <= '0;
        end else if (state == UPDATE) begin
            for (int g = 1; g <= 6; g++)
                if (grp_q == GRP_W'(g))
                    cnt[g] <= cnt[g] + 1'b1;
        end
    end

    assign busy = (state != IDLE);
    assign Grp1 = cnt[1];
    assign Grp2 = cnt[2];
    assign Grp3 = cnt[3];
    assign Grp4 = cnt[4];
    assign Grp5 = cnt[5];
    assign Grp6 = cnt[6];

endmodule

// File: tb/tb_sorter_scheduler.sv
// Directed bench for sorter_scheduler: arbitration order,
// classification boundaries, wrap, clr priority, reset abort.
module tb_sorter_scheduler;

    localparam int N = 4;
    localparam int W = 12;
    localparam int C = 8;

    logic         clk;
    logic         reset;
    logic [N-1:0] req;
    logic [N*W-1:0] weight;
    logic         clr;
    logic [N-1:0] ack;
    logic [2:0]   ack_grp;
    logic         busy;
    logic [C-1:0] g1, g2, g3, g4, g5, g6;

    int total;
    int bad;

    sorter_scheduler #(
        .N_REQ(N), .W_WIDTH(W), .CNT_WIDTH(C)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .weight(weight),
        .clr(clr), .ack(ack), .ack_grp(ack_grp), .busy(busy),
        .Grp1(g1), .Grp2(g2), .Grp3(g3),
        .Grp4(g4), .Grp5(g5), .Grp6(g6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic check_cnts(input string tag,
                              input int e1, input int e2,
                              input int e3, input int e4,
                              input int e5, input int e6);
        check({tag, ".g1"}, 32'(g1), 32'(e1));
        check({tag, ".g2"}, 32'(g2), 32'(e2));
        check({tag, ".g3"}, 32'(g3), 32'(e3));
        check({tag, ".g4"}, 32'(g4), 32'(e4));
        check({tag, ".g5"}, 32'(g5), 32'(e5));
        check({tag, ".g6"}, 32'(g6), 32'(e6));
    endtask

    task automatic do_reset();
        reset  = 1'b0;
        req    = '0;
        clr    = 1'b0;
        weight = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic wait_ack(input string tag, output int cyc);
        bit seen;
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (ack != '0)
                seen = 1'b1;
        end
        if (!seen)
            check({tag, ".timeout"}, 32'd0, 32'd1);
    endtask

    task automatic do_txn(input string tag, input int s,
                          input int w, input int eg);
        int cyc;
        weight[s*W +: W] = W'(w);
        req[s] = 1'b1;
        wait_ack(tag, cyc);
        check({tag, ".ack"}, 32'(ack), 32'(1 << s));
        check({tag, ".grp"}, 32'(ack_grp), 32'(eg));
        req[s] = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int cyc;
        int ws [4];
        int gs [4];
        int b3w [4];
        int b3g [4];
        total = 0;
        bad   = 0;
        ws  = '{0, 300, 800, 2500};
        gs  = '{0, 2, 4, 6};
        b3w = '{250, 251, 2000, 2001};
        b3g = '{1, 2, 5, 6};

        do_reset();
        check("rst.ack", 32'(ack), 32'd0);
        check("rst.grp", 32'(ack_grp), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        check_cnts("rst", 0, 0, 0, 0, 0, 0);

        // 1: single request, latency and counter
        weight[0 +: W] = 12'd100;
        req[0] = 1'b1;
        wait_ack("t1", cyc);
        check("t1.lat", 32'(cyc), 32'd3);
        check("t1.ack", 32'(ack), 32'b0001);
        check("t1.grp", 32'(ack_grp), 32'd1);
        check_cnts("t1", 1, 0, 0, 0, 0, 0);
        req[0] = 1'b0;
        @(negedge clk);
        check("t1.pulse", 32'(ack), 32'd0);
        check("t1.hold", 32'(ack_grp), 32'd1);

        // 2: all four request at once
        do_reset();
        for (int i = 0; i < 4; i++)
            weight[i*W +: W] = W'(ws[i]);
        req = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            wait_ack("t2", cyc);
            check($sformatf("t2.ack%0d", i), 32'(ack), 32'(1 << i));
            check($sformatf("t2.grp%0d", i), 32'(ack_grp), 32'(gs[i]));
            req[i] = 1'b0;
        end
        @(negedge clk);
        check_cnts("t2", 0, 1, 0, 1, 0, 1);

        // 3: classification boundaries on station 2
        for (int i = 0; i < 4; i++)
            do_txn($sformatf("t3.%0d", i), 2, b3w[i], b3g[i]);

        // 4: held request blocks further grants
        do_reset();
        weight[1*W +: W] = 12'd500;
        weight[3*W +: W] = 12'd1000;
        req[1] = 1'b1;
        wait_ack("t4a", cyc);
        check("t4.ack1", 32'(ack), 32'b0010);
        req[3] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("t4.hold%0d", i), 32'(ack), 32'd0);
        end
        check("t4.busy", 32'(busy), 32'd1);
        req[1] = 1'b0;
        wait_ack("t4b", cyc);
        check("t4.ack3", 32'(ack), 32'b1000);
        check("t4.grp3", 32'(ack_grp), 32'd4);
        req[3] = 1'b0;
        @(negedge clk);
        check_cnts("t4", 0, 1, 0, 1, 0, 0);

        // 5: wrap of Grp1 and clr in UPDATE
        do_reset();
        for (int i = 0; i < 255; i++)
            do_txn("t5", 0, 10, 1);
        check("t5.g255", 32'(g1), 32'd255);
        do_txn("t5", 0, 10, 1);
        check("t5.wrap", 32'(g1), 32'd0);
        do_txn("t5", 0, 10, 1);
        check("t5.one", 32'(g1), 32'd1);
        req[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("t5.clr.ack", 32'(ack), 32'b0001);
        check("t5.clr.g1", 32'(g1), 32'd0);
        req[0] = 1'b0;
        @(negedge clk);

        // 6: reset during SAMPLE aborts
        do_txn("t6a", 0, 10, 1);
        weight[1*W +: W] = 12'd300;
        req[1] = 1'b1;
        @(negedge clk);
        check("t6.busy", 32'(busy), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        check("t6.ack", 32'(ack), 32'd0);
        check("t6.grp", 32'(ack_grp), 32'd0);
        check("t6.idle", 32'(busy), 32'd0);
        check_cnts("t6", 0, 0, 0, 0, 0, 0);
        weight[0 +: W] = 12'd600;
        req[0] = 1'b1;
        reset = 1'b1;
        wait_ack("t6b", cyc);
        check("t6.prio", 32'(ack), 32'b0001);
        check("t6.grp0", 32'(ack_grp), 32'd3);
        req = '0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
